// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: opcodes, control-bus bit layout,
// sequencer states and per-opcode last microstep.
package control_sequencer_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_STA = 4'd4;
   localparam logic [3:0] OP_LDI = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_JC  = 4'd7;
   localparam logic [3:0] OP_JZ  = 4'd8;
   localparam logic [3:0] OP_OUT = 4'd14;
   localparam logic [3:0] OP_HLT = 4'd15;

   localparam int B_HLT = 15;
   localparam int B_MI  = 14;
   localparam int B_RI  = 13;
   localparam int B_RO  = 12;
   localparam int B_IO  = 11;
   localparam int B_II  = 10;
   localparam int B_AI  = 9;
   localparam int B_AO  = 8;
   localparam int B_EO  = 7;
   localparam int B_SU  = 6;
   localparam int B_BI  = 5;
   localparam int B_OI  = 4;
   localparam int B_CE  = 3;
   localparam int B_CO  = 2;
   localparam int B_J   = 1;
   localparam int B_FI  = 0;

   localparam logic [15:0] M_HLT = 16'(1) << B_HLT;
   localparam logic [15:0] M_MI  = 16'(1) << B_MI;
   localparam logic [15:0] M_RI  = 16'(1) << B_RI;
   localparam logic [15:0] M_RO  = 16'(1) << B_RO;
   localparam logic [15:0] M_IO  = 16'(1) << B_IO;
   localparam logic [15:0] M_II  = 16'(1) << B_II;
   localparam logic [15:0] M_AI  = 16'(1) << B_AI;
   localparam logic [15:0] M_AO  = 16'(1) << B_AO;
   localparam logic [15:0] M_EO  = 16'(1) << B_EO;
   localparam logic [15:0] M_SU  = 16'(1) << B_SU;
   localparam logic [15:0] M_BI  = 16'(1) << B_BI;
   localparam logic [15:0] M_OI  = 16'(1) << B_OI;
   localparam logic [15:0] M_CE  = 16'(1) << B_CE;
   localparam logic [15:0] M_CO  = 16'(1) << B_CO;
   localparam logic [15:0] M_J   = 16'(1) << B_J;
   localparam logic [15:0] M_FI  = 16'(1) << B_FI;

   localparam logic [2:0] LAST_T2 = 3'd2;
   localparam logic [2:0] LAST_T3 = 3'd3;
   localparam logic [2:0] LAST_T4 = 3'd4;
   localparam logic [2:0] MAX_STEP = 3'd4;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_e;

   function automatic logic [2:0] last_step_of(input logic [3:0] opc);
      case (opc)
         OP_LDA, OP_STA: return LAST_T3;
         OP_ADD, OP_SUB: return LAST_T4;
         default:        return LAST_T2;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_microstep_counter.sv
// Microstep counter: wraps to 0 after the last step, never exceeds T4, and
// recovers from illegal values on the next enabled edge.
module microstep_counter
   import control_sequencer_pkg::*;
#(
   parameter int STEP_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic [STEP_W-1:0] last_step,
   output logic [STEP_W-1:0] step
);

   logic [STEP_W-1:0] step_q, step_d;

   always_comb begin
      step_d = step_q;
      if (clear) begin
         step_d = '0;
      end else if (enable) begin
         if (step_q >= last_step || step_q >= STEP_W'(MAX_STEP)) step_d = '0;
         else                                                     step_d = step_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) step_q <= '0;
      else        step_q <= step_d;
   end

   assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: RUN/HALT FSM plus per-step control-word decode
// for an 8-bit breadboard-style CPU.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int STEP_W = 3,
   parameter int OPC_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step_en,
   input  logic [OPC_W-1:0]  opcode,
   input  logic              carry_flag,
   input  logic              zero_flag,
   input  logic              resume,
   output logic [15:0]       ctrl_word,
   output logic [STEP_W-1:0] step,
   output logic              halted
);

   seq_state_e        state_q, state_d;
   logic              cnt_clear, cnt_en;
   logic [3:0]        op;
   logic [STEP_W-1:0] last_step;
   logic [15:0]       decode_word;

   assign op        = 4'(opcode);
   assign last_step = STEP_W'(last_step_of(op));

   microstep_counter #(.STEP_W(STEP_W)) u_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (cnt_clear),
      .enable    (cnt_en),
      .last_step (last_step),
      .step      (step)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         ST_RUN: begin
            cnt_en = step_en;
            if (step_en && op == OP_HLT && step == STEP_W'(2)) begin
               state_d   = ST_HALT;
               cnt_clear = 1'b1;
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_d   = ST_RUN;
               cnt_clear = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // Fetch is opcode-independent; execute steps decode the live opcode and flags.
   always_comb begin
      decode_word = '0;
      if (step == STEP_W'(0)) begin
         decode_word = M_CO | M_MI;
      end else if (step == STEP_W'(1)) begin
         decode_word = M_RO | M_II | M_CE;
      end else begin
         case (op)
            OP_LDA: if (step == STEP_W'(2))      decode_word = M_IO | M_MI;
                    else if (step == STEP_W'(3)) decode_word = M_RO | M_AI;
            OP_ADD, OP_SUB: begin
               if (step == STEP_W'(2))      decode_word = M_IO | M_MI;
               else if (step == STEP_W'(3)) decode_word = M_RO | M_BI;
               else if (step == STEP_W'(4))
                  decode_word = M_EO | M_AI | M_FI | ((op == OP_SUB) ? M_SU : 16'h0000);
            end
            OP_STA: if (step == STEP_W'(2))      decode_word = M_IO | M_MI;
                    else if (step == STEP_W'(3)) decode_word = M_AO | M_RI;
            OP_LDI: if (step == STEP_W'(2)) decode_word = M_IO | M_AI;
            OP_JMP: if (step == STEP_W'(2)) decode_word = M_IO | M_J;
            OP_JC:  if (step == STEP_W'(2) && carry_flag) decode_word = M_IO | M_J;
            OP_JZ:  if (step == STEP_W'(2) && zero_flag)  decode_word = M_IO | M_J;
            OP_OUT: if (step == STEP_W'(2)) decode_word = M_AO | M_OI;
            OP_HLT: if (step == STEP_W'(2)) decode_word = M_HLT;
            OP_NOP: decode_word = '0;
            default: decode_word = '0;
         endcase
      end
   end

   assign ctrl_word = (rst_n && step_en && state_q == ST_RUN) ? decode_word : 16'h0000;
   assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter STEP_W, default 3, SHALL be the width of the microstep counter.
REQ-002 Parameter OPC_W, default 4, SHALL be the width of the opcode input.
REQ-003 Port clk  in  1  SHALL be the single system clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port step_en  in  1  SHALL be the clock-enable; state advances only on edges where step_en=1.
REQ-006 Port opcode  in  OPC_W  SHALL be the instruction register's upper nibble, valid from step T2 onward.
REQ-007 Port carry_flag  in  1  SHALL be the latched carry flag from the flags register.
REQ-008 Port zero_flag  in  1  SHALL be the latched zero flag from the flags register.
REQ-009 Port resume  in  1  SHALL be the request to leave HALT.
REQ-010 Port ctrl_word  out  16  SHALL be the control bus, with bits 15..0 = hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi.
REQ-011 Port step  out  STEP_W  SHALL be the current microstep (0..4).
REQ-012 Port halted  out  1  SHALL be high while in HALT.

Function
REQ-013 The sequencer SHALL have two states, RUN and HALT; the microstep counter SHALL cover T0..T4.
REQ-014 ctrl_word SHALL be combinational from (state, step, opcode, flags) and SHALL be forced to 0 when step_en=0 or state=HALT.
REQ-015 T0 SHALL drive co|mi and T1 SHALL drive ro|ii|ce, for every opcode.
REQ-016 T2..T4 SHALL be decoded per opcode as follows:
- LDA(1): io|mi, ro|ai
- ADD(2): io|mi, ro|bi, eo|ai|fi
- SUB(3): as ADD with su added at T4
- STA(4): io|mi, ao|ri
- LDI(5): io|ai
- JMP(6): io|j
- JC(7): io|j if carry_flag=1, else 0
- JZ(8): io|j if zero_flag=1, else 0
- OUT(14): ao|oi
- HLT(15): hlt
- NOP(0) and undefined opcodes: 0
REQ-017 The last step SHALL be T3 for LDA/STA, T4 for ADD/SUB, and T2 for all other opcodes, including an untaken JC/JZ.
REQ-018 On an enabled edge in RUN, step SHALL go to 0 if it is the last step; otherwise step SHALL increment. There are no idle microsteps.
REQ-019 On the enabled edge at HLT T2, state SHALL become HALT and step SHALL become 0; hlt SHALL be visible for exactly that one cycle.
REQ-020 In HALT, the first edge with resume=1 SHALL return state to RUN with step=0; step_en SHALL NOT be required for this edge.
REQ-021 resume SHALL be ignored in RUN.
REQ-022 Flags SHALL be sampled only combinationally at T2 of JC/JZ; flag changes at other steps SHALL have no effect.
REQ-023 opcode SHALL be ignored at T0/T1.
REQ-024 An opcode change mid-instruction SHALL alter decode immediately; no latching is done here.
REQ-025 Step SHALL never exceed 4; if an illegal step value occurs, the next enabled edge SHALL force step to 0.

Reset
REQ-026 While rst_n=0: state=RUN, step=0, halted=0, ctrl_word=0, all asynchronously.
REQ-027 Reset asserted mid-instruction SHALL abandon that instruction; after release, the first enabled cycle SHALL be T0.

Structure
REQ-028 A shared package SHALL hold the opcode constants, ctrl_word bit indices and masks, the state enum, and last-step values.
REQ-029 The single sub-module SHALL be microstep_counter (clear, enable, last-step input, step output); decode and the halt FSM SHALL stay in control_sequencer.

Verification
REQ-030 Reset, then step_en=1 with opcode=5 (LDI) -> ctrl_word 0x4004, 0x1408, 0x0A00, then step returns to 0.
REQ-031 ADD sequence -> T2=0x4800, T3=0x1020, T4=0x0281, then T0; SUB T4=0x02C1.
REQ-032 JC with carry_flag=0 -> T2 ctrl_word=0x0000, step goes to 0; with carry_flag=1 -> T2=0x0802.
REQ-033 HLT -> T2=0x8000 for one cycle, then halted=1 and ctrl_word=0 for 10 cycles; pulse resume -> next cycle step=0, halted=0, ctrl_word=0x4004.
REQ-034 step_en low for 3 cycles at ADD T3 -> step holds at 3 and ctrl_word=0; resumes at 0x1020.
REQ-035 rst_n pulsed low asynchronously at STA T3 -> ctrl_word=0 immediately; after release, T0=0x4004.
